axi_ar_rr_arbiter: RTL
======================

# axi_ar_rr_arbiter

Round-robin read-channel arbiter that lets M masters share one AXI3 read slave (one `Memory` read port). It grants one master's AR request at a time, forwards it to the slave with the master index prepended to ARID, and routes the R burst back to that master. The grant is held until the RLAST beat completes. It sits in `top` between the master read-request FIFOs and each slave's read port.

## Interface
- `M`, 2, number of masters (2..8)
- `ID_WIDTH`, 1, master-side ARID/RID width
- `ADDR_WIDTH`, 32, address width
- `BUS_WIDTH`, 32, read data width
- `MW`, $clog2(M), derived; master index width
- `clk`  in  1  single clock; all logic on its rising edge
- `clr`  in  1  reset, synchronous, active-low
- `m_arvalid`  in  M  per-master AR valid
- `m_arready`  out  M  per-master AR ready
- `m_araddr`  in  M*ADDR_WIDTH  packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `m_arid`  in  M*ID_WIDTH  packed ARID
- `m_arlen`  in  M*4  packed ARLEN (beats-1)
- `m_arsize`, `m_arburst`  in  M*2 each  packed ARSIZE / ARBURST
- `s_arvalid`  out  1  slave AR valid
- `s_arready`  in  1  slave AR ready
- `s_araddr`  out  ADDR_WIDTH; `s_arlen` out 4; `s_arsize`, `s_arburst` out 2 each
- `s_arid`  out  MW+ID_WIDTH  {grant index, master ARID}
- `s_rvalid`, `s_rlast`  in  1 each; `s_rdata` in BUS_WIDTH; `s_rid` in MW+ID_WIDTH
- `s_rready`  out  1
- `m_rvalid`, `m_rlast`  out  M each  one-hot to the granted master
- `m_rready`  in  M
- `m_rdata`  out  BUS_WIDTH; `m_rid` out ID_WIDTH  shared, qualified by m_rvalid

## Operation
- State machine with states IDLE, ADDR, DATA.
- IDLE: if any `m_arvalid` is high, pick the first requester at or after `rr_ptr` (search wraps modulo M), register it as `gnt`, and go to ADDR. Otherwise stay in IDLE.
- ADDR: `s_arvalid`=1. `s_ar*` is a combinational mux of master `gnt` inputs. `m_arready[gnt]`=`s_arready`; all other `m_arready` bits are 0. On `s_arvalid & s_arready`, go to DATA.
- DATA: `m_rvalid[gnt]`=`s_rvalid`, `m_rlast[gnt]`=`s_rlast`, `m_rdata`=`s_rdata`, `m_rid`=`s_rid[ID_WIDTH-1:0]`, `s_rready`=`m_rready[gnt]`. All non-granted `m_rvalid`/`m_rlast` bits are 0.
- On the `s_rvalid & s_rready & s_rlast` handshake: `rr_ptr` <= (`gnt`+1) mod M, then go to IDLE.
- One outstanding read per slave. Routing uses `gnt`, not `s_rid`. A mismatch between `s_rid[MW+ID_WIDTH-1 -: MW]` and `gnt` sets sticky `id_err` (internal, visible to the bench via hierarchy). Routing is unaffected.
- If `m_arvalid[gnt]` drops while in ADDR (protocol violation), the grant is held and `s_arvalid` stays 1.
- Burst length does not matter; only RLAST ends the grant. ARLEN=0 is a single beat.

## Timing
- Reset (`clr`=0 at a rising edge): state=IDLE, `rr_ptr`=0, `gnt`=0, `id_err`=0. Every output is 0: `s_arvalid`, `m_arready`, `s_rready`, `m_rvalid`, `m_rlast`, `s_ar*`, `s_arid`, `m_rdata`, `m_rid`.
- Reset asserted mid-burst abandons the burst. Slave R beats after reset see `s_rready`=0.
- Request latency: `m_arvalid` high in cycle n while in IDLE gives `s_arvalid`=1 in cycle n+1.
- AR and R paths are pass-through: ready, valid and data add no latency.
- Minimum gap: RLAST handshake in cycle n, back in IDLE at n+1, next `s_arvalid` at n+2.
- Simultaneous requests are resolved by `rr_ptr` only. A master that requests during another's burst wins the next IDLE arbitration if it is next in rotation.
- `rr_ptr` wraps from M-1 to 0.

## Structure
- Shared package `axi_pkg`:
  - state enum `ar_arb_state_t` {IDLE, ADDR, DATA}
  - burst codes FIXED=0, INCR=1, WRAP=2
  - `AXI_LEN_W`=4, `AXI_SIZE_W`=2
- One sub-module `rr_pick`: purely combinational. Inputs `req[M]` and `ptr`; outputs `valid` and `idx`. The first set bit at or after `ptr` wins, wrapping.
- The top level holds the FSM, the `gnt`/`rr_ptr` registers and the muxes.

## Test plan
- Master 0 alone: ARADDR 0x80, ARLEN 3, ARID 0. Expect `s_arvalid` 1 cycle later, `s_arid`=2'b00, 4 beats on master 0 only, then IDLE.
- Both masters request in the same cycle after reset: master 0 (0x80) is granted first. Master 1 (0x00, ARLEN 2) is granted 2 cycles after master 0's RLAST, with `s_arid`=2'b10.
- Fairness: both masters hold `m_arvalid` continuously for 6 bursts. Expect grants 0,1,0,1,0,1.
- Back-pressure: `s_arready` low for 5 cycles in ADDR, and `m_rready[gnt]` toggling during DATA. Expect AR fields stable, `m_arready` pulsing exactly once, no lost or duplicated beats.
- Reset during beat 2 of an ARLEN 3 burst: all outputs are 0 the next cycle. The following request from master 1 is granted (`rr_ptr`=0 and master 0 idle).
- Slave returns `s_rid`=2'b10 while `gnt`=0: beats still go to master 0 and `id_err`=1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel definitions for the AR round-robin arbiter.
package axi_pkg;

    localparam int AXI_LEN_W  = 4;
    localparam int AXI_SIZE_W = 2;

    // ARBURST encodings
    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ar_arb_state_t;

endpackage

// File: rtl/axi_ar_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int M  = 2,
    parameter int MW = 1
) (
    input  logic [M-1:0]  req,
    input  logic [MW-1:0] ptr,
    output logic          valid,
    output logic [MW-1:0] idx
);

    // Scan M slots starting at ptr; the first hit wins.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < M; k++) begin
            j = (int'(ptr) + k) % M;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = MW'(j);
            end
        end
    end

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin AR/R arbiter: M masters share one AXI3 read slave, one burst at a time.
module axi_ar_rr_arbiter
    import axi_pkg::*;
#(
    parameter int M          = 2,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int MW         = $clog2(M)
) (
    input  logic                       clk,
    input  logic                       clr,
    // master AR side
    input  logic [M-1:0]               m_arvalid,
    output logic [M-1:0]               m_arready,
    input  logic [M*ADDR_WIDTH-1:0]    m_araddr,
    input  logic [M*ID_WIDTH-1:0]      m_arid,
    input  logic [M*AXI_LEN_W-1:0]     m_arlen,
    input  logic [M*AXI_SIZE_W-1:0]    m_arsize,
    input  logic [M*2-1:0]             m_arburst,
    // slave AR side
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [ADDR_WIDTH-1:0]      s_araddr,
    output logic [AXI_LEN_W-1:0]       s_arlen,
    output logic [AXI_SIZE_W-1:0]      s_arsize,
    output logic [1:0]                 s_arburst,
    output logic [MW+ID_WIDTH-1:0]     s_arid,
    // slave R side
    input  logic                       s_rvalid,
    input  logic                       s_rlast,
    input  logic [BUS_WIDTH-1:0]       s_rdata,
    input  logic [MW+ID_WIDTH-1:0]     s_rid,
    output logic                       s_rready,
    // master R side
    output logic [M-1:0]               m_rvalid,
    output logic [M-1:0]               m_rlast,
    input  logic [M-1:0]               m_rready,
    output logic [BUS_WIDTH-1:0]       m_rdata,
    output logic [ID_WIDTH-1:0]        m_rid
);

    ar_arb_state_t   state_q;
    logic [MW-1:0]   gnt_q;
    logic [MW-1:0]   rr_ptr_q;
    logic            id_err_q;

    logic            pick_vld;
    logic [MW-1:0]   pick_idx;
    logic [31:0]     gnt_ix;
    logic [MW-1:0]   rid_gnt;
    logic            r_hs;

    rr_pick #(
        .M  (M),
        .MW (MW)
    ) u_pick (
        .req   (m_arvalid),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign gnt_ix  = 32'(gnt_q);
    assign rid_gnt = s_rid[MW+ID_WIDTH-1 -: MW];
    assign r_hs    = (state_q == DATA) && s_rvalid && s_rready;

    // AR path: forward the granted master's request while in ADDR, zero otherwise.
    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arid    = '0;
        m_arready = '0;
        if (state_q == ADDR) begin
            s_arvalid        = 1'b1;
            s_araddr         = m_araddr [gnt_ix*ADDR_WIDTH +: ADDR_WIDTH];
            s_arlen          = m_arlen  [gnt_ix*AXI_LEN_W  +: AXI_LEN_W];
            s_arsize         = m_arsize [gnt_ix*AXI_SIZE_W +: AXI_SIZE_W];
            s_arburst        = m_arburst[gnt_ix*2          +: 2];
            s_arid           = {gnt_q, m_arid[gnt_ix*ID_WIDTH +: ID_WIDTH]};
            m_arready[gnt_q] = s_arready;
        end
    end

    // R path: steer beats to the granted master by gnt, never by s_rid.
    always_comb begin
        s_rready = 1'b0;
        m_rvalid = '0;
        m_rlast  = '0;
        m_rdata  = '0;
        m_rid    = '0;
        if (state_q == DATA) begin
            s_rready        = m_rready[gnt_q];
            m_rvalid[gnt_q] = s_rvalid;
            m_rlast[gnt_q]  = s_rvalid & s_rlast;
            m_rdata         = s_rdata;
            m_rid           = s_rid[ID_WIDTH-1:0];
        end
    end

    // Arbitration FSM: pick in IDLE, hold grant through AR handshake and until RLAST.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            id_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_idx;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    // a master dropping arvalid here does not release the grant
                    if (s_arready) state_q <= DATA;
                end
                DATA: begin
                    if (r_hs && (rid_gnt != gnt_q)) id_err_q <= 1'b1;
                    if (r_hs && s_rlast) begin
                        rr_ptr_q <= (gnt_q == MW'(M-1)) ? '0 : gnt_q + 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
